// File: rtl/dmem_responder.sv
// dmem_responder: byte-addressed 8/16/32-bit load/store responder over word-only storage.
// Ports: clk/rst; req_valid/req_ready/req_addr/req_write/req_wdata/req_width request side;
//        resp_valid/resp_rdata/resp_err one-cycle response pulse (no backpressure).
// Latency 1..5 cycles after handshake; req_ready is low from acceptance through RESP.
// Optional feature macro: DMEM_MISALIGNED_EN (split misaligned H/W accesses into two words).
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_width,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

`ifdef DMEM_MISALIGNED_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, RD1 = 3'd1, WR1 = 3'd2, RESP = 3'd3, RD2 = 3'd4, WR2 = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, RD1 = 3'd1, WR1 = 3'd2, RESP = 3'd3
  } state_t;
`endif

  logic [31:0] mem [DEPTH_WORDS];

  state_t           state, state_n;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       off_q;
  logic [1:0]       size_q;
  logic             write_q;
  logic [31:0]      wdata_q;
  logic [31:0]      word0, word1;
  logic [31:0]      rdata_q;
  logic             err_q;
`ifdef DMEM_MISALIGNED_EN
  logic             mis_q;
  logic [IDX_W-1:0] idx1;
  assign idx1 = idx_q + IDX_W'(1);  // wraps past the last word back to word 0
`endif

  // Request decode
  logic req_fire, in_legal, in_mis, in_bad;
  assign req_ready = (state == IDLE) && !rst;
  assign req_fire  = req_valid && req_ready;

  always_comb begin
    in_legal = 1'b0;
    if (req_write) in_legal = (req_width == 3'b000) || (req_width == 3'b001) || (req_width == 3'b010);
    else           in_legal = (req_width == 3'b000) || (req_width == 3'b001) || (req_width == 3'b010) ||
                              (req_width == 3'b100) || (req_width == 3'b101);
  end
  assign in_mis = ((req_width[1:0] == 2'b01) && req_addr[0]) ||
                  ((req_width[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`ifdef DMEM_MISALIGNED_EN
  assign in_bad = !in_legal;
`else
  assign in_bad = !in_legal || in_mis;
`endif

  // Lane datapath: 64-bit window {word1, word0} shifted by the byte offset
  logic [31:0] mask32;
  logic [4:0]  lane_sh;
  logic [63:0] rd_cat, rd_shift, wr_mask, wr_data, merged;
  logic [31:0] ext;

  always_comb begin
    case (size_q)
      2'b00:   mask32 = 32'h0000_00FF;
      2'b01:   mask32 = 32'h0000_FFFF;
      default: mask32 = 32'hFFFF_FFFF;
    endcase
  end
  assign lane_sh = {off_q, 3'b000};

  // Extraction taps the word being read this cycle so the response can be registered on entry to RESP.
  always_comb begin
    rd_cat = {word1, word0};
    if (state == RD1) rd_cat[31:0] = mem[idx_q];
`ifdef DMEM_MISALIGNED_EN
    if (state == RD2) rd_cat[63:32] = mem[idx1];
`endif
  end
  assign rd_shift = rd_cat >> lane_sh;
  assign ext      = rd_shift[31:0] & mask32;

  assign wr_mask = {32'h0, mask32} << lane_sh;
  assign wr_data = {32'h0, wdata_q & mask32} << lane_sh;
  assign merged  = ({word1, word0} & ~wr_mask) | (wr_data & wr_mask);
`ifndef DMEM_MISALIGNED_EN
  logic unused_merged_hi;
  assign unused_merged_hi = ^merged[63:32];
`endif

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (req_fire) begin
          if (in_bad)                                                   state_n = RESP;
          else if (req_write && req_width[1:0] == 2'b10 && !in_mis)    state_n = WR1;
          else                                                          state_n = RD1;
        end
      end
      RD1: begin
`ifdef DMEM_MISALIGNED_EN
        if (mis_q)        state_n = RD2;
        else
`endif
        if (write_q)      state_n = WR1;
        else              state_n = RESP;
      end
`ifdef DMEM_MISALIGNED_EN
      RD2:                state_n = write_q ? WR1 : RESP;
      WR1:                state_n = mis_q ? WR2 : RESP;
      WR2:                state_n = RESP;
`else
      WR1:                state_n = RESP;
`endif
      RESP:               state_n = IDLE;
      default:            state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx_q   <= '0;
      off_q   <= 2'b00;
      size_q  <= 2'b00;
      write_q <= 1'b0;
      wdata_q <= 32'h0;
      word0   <= 32'h0;
      word1   <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
`ifdef DMEM_MISALIGNED_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (req_fire) begin
        idx_q   <= req_addr[IDX_W+1:2];
        off_q   <= req_addr[1:0];
        size_q  <= req_width[1:0];
        write_q <= req_write;
        wdata_q <= req_wdata;
`ifdef DMEM_MISALIGNED_EN
        mis_q   <= in_mis;
`endif
      end
      if (state == RD1) word0 <= mem[idx_q];
`ifdef DMEM_MISALIGNED_EN
      if (state == RD2) word1 <= mem[idx1];
`endif
      // Response is registered on entry to RESP and forced to zero elsewhere.
      if (state_n == RESP) begin
        rdata_q <= (state == IDLE || write_q) ? 32'h0 : ext;
        err_q   <= (state == IDLE);
      end else begin
        rdata_q <= 32'h0;
        err_q   <= 1'b0;
      end
    end
  end

  // Backing store: not reset; a reset asserted mid-operation returns to IDLE so no further writes occur.
  always_ff @(posedge clk) begin
    if (state == WR1) mem[idx_q] <= merged[31:0];
`ifdef DMEM_MISALIGNED_EN
    if (state == WR2) mem[idx1]  <= merged[63:32];
`endif
  end

  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the memory-access stage. It accepts one load/store request at a time over a valid/ready handshake and serves byte-addressed 8/16/32-bit accesses from word-only (32-bit) backing storage, using read-modify-write for sub-word stores. Load data is returned right-aligned and zero-filled; sign/zero extension stays in the stage's extender.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: backing store depth in 32-bit words; power of two.
- `IDX_W`, $clog2(DEPTH_WORDS): word-index width.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept; high only in IDLE and never while `rst` is high.
- `req_addr` in 32: byte address. Word index is `req_addr[IDX_W+1:2]`; upper bits are ignored, so the address space wraps.
- `req_write` in 1: 1 = store, 0 = load.
- `req_wdata` in 32: store data, right-aligned.
- `req_width` in 3: funct3 width code.
  - Loads: 000 B, 001 H, 010 W, 100 BU, 101 HU.
  - Stores: 000, 001, 010.
- `resp_valid` out 1: one-cycle pulse per accepted request; no backpressure.
- `resp_rdata` out 32: load data, right-aligned, upper bits 0. It is 0 for stores and errors.
- `resp_err` out 1: qualified by `resp_valid`; illegal width or (when the feature is disabled) misaligned access.

## Operation
- A request is accepted when `req_valid && req_ready` at a rising edge. `req_addr`, `req_write`, `req_wdata`, `req_width` and `req_addr[1:0]` are captured at acceptance; inputs are ignored afterwards.
- Size is 1, 2 or 4 bytes. An access is misaligned if it is an H access with addr[0]=1, or a W access with addr[1:0]≠0.
- Illegal codes:
  - Loads: 011, 110, 111.
  - Stores: any code other than 000/001/010.
  - An illegal code goes IDLE→RESP with `resp_err`=1 and no memory write.
- FSM states: IDLE, RD1, RD2, WR1, WR2, RESP.
  - Aligned load: IDLE→RD1 (capture word0 = mem[idx])→RESP.
  - Aligned SW: IDLE→WR1 (full-word write)→RESP.
  - Aligned SB/SH: IDLE→RD1→WR1 (merge byte lanes into word0, write)→RESP.
  - Misaligned load: IDLE→RD1→RD2 (word1 = mem[idx+1 mod DEPTH_WORDS])→RESP.
  - Misaligned store: IDLE→RD1→RD2→WR1 (word0 merged)→WR2 (word1 merged)→RESP.
  - RESP→IDLE unconditionally.
- Lane extraction: the 64-bit concatenation {word1, word0} is shifted right by 8*addr[1:0], then masked to the access size.
- Lane merge for stores: bytes at lanes addr[1:0]..addr[1:0]+size-1 are replaced, and the overflow bytes go to word1 lanes from 0 upward. All other bytes are preserved.
- `resp_rdata` and `resp_err` are registered and valid only during RESP. Outside RESP they are held at 0.

## Timing
- Handshake occurs in cycle 0. `resp_valid` rises in:
  - cycle 2 for an aligned load or SW;
  - cycle 3 for an aligned SB/SH or a misaligned load;
  - cycle 5 for a misaligned store;
  - cycle 1 for an error.
- `req_ready` is low from cycle 1 through the RESP cycle. The earliest next acceptance is the cycle after RESP; throughput is therefore ≤1 request per 2 cycles.
- A store's write is visible to a load accepted at any later handshake.
- Reset values: state IDLE, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, internal word registers 0. Memory contents are not reset.
- Reset mid-operation aborts immediately with no response. A misaligned store aborted after WR1 leaves word0 updated and word1 unchanged; this is accepted behaviour.
- Wrap-around: a misaligned access at the last word pairs it with word 0.

## Configuration
- `DMEM_MISALIGNED_EN` defined: misaligned H/W accesses are split into two word accesses as described above, with `resp_err`=0.
- Not defined: a misaligned access goes IDLE→RESP with `resp_err`=1, `resp_rdata`=0 and no write. RD2/WR2 are not built.

## Test plan
- Reset asserted mid-RD1 → `resp_valid`=0, `req_ready`=0 during reset, `req_ready`=1 the cycle after deassert. No response is emitted for the aborted request.
- SW 0x11223344 @0x10, then LB @0x11 and LHU @0x12 → `resp_rdata`=0x00000033 at cycle 2, then 0x00001122 at cycle 2.
- SB 0xAB @0x13 over 0x11223344, then LW @0x10 → SB acknowledged at cycle 3; LW returns 0xAB223344.
- Illegal width 011 load, and 100 store, @0x0 → `resp_err`=1 at cycle 1. Memory at 0x0 is unchanged on read-back.
- With `DMEM_MISALIGNED_EN`, using a word-address mask `W` = (DEPTH_WORDS*4 − 4):
  - memory initialised with mem[W/4]=0xAABBCCDD and mem[0]=0x44332211;
  - LW @W+2 → 0x2211AABB at cycle 3;
  - SW 0x55667788 @0x1 → ack at cycle 5; afterwards word0=0x667788xx and word1=0xxxxxxx55, with the original bytes preserved.
- Without `DMEM_MISALIGNED_EN`: LH @0x1 → `resp_err`=1 at cycle 1. SW @0x2 → `resp_err`=1, and the affected words are unchanged.
